// File: rtl/spi_ip_pkg.sv
// Shared definitions for the SPI serial-clock generator: FSM state
// encodings, CPOL/CPHA bit positions within the latched mode field and
// the default port widths.
package spi_ip_pkg;

    localparam int DEF_DIV_WIDTH   = 8;
    localparam int DEF_BITS_WIDTH  = 6;
    localparam int DEF_GUARD_WIDTH = 4;

    // Bit positions inside the two-bit latched mode field
    localparam int MODE_CPHA_BIT = 0;
    localparam int MODE_CPOL_BIT = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_TRAIL = 3'd3,
        ST_LAG   = 3'd4,
        ST_DONE  = 3'd5
    } sckg_state_e;

endpackage

// File: rtl/spi_ip_sclk_tick.sv
// Loadable half-period counter. Counts 0..limit_i, flags tick_o while the
// count equals limit_i and wraps to 0 on the following edge. clear_i forces
// the count back to 0. Also used to time the guard intervals.
module spi_ip_sclk_tick #(
    parameter int PARAM_CNT_WIDTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       clear_i,
    input  logic [PARAM_CNT_WIDTH-1:0] limit_i,
    output logic                       tick_o
);

    logic [PARAM_CNT_WIDTH-1:0] cnt_q;
    logic [PARAM_CNT_WIDTH-1:0] cnt_d;

    assign tick_o = (cnt_q == limit_i);

    // Next count: clear has priority, then wrap on tick, otherwise count up
    always_comb begin
        cnt_d = cnt_q + PARAM_CNT_WIDTH'(1);
        if (clear_i || tick_o) begin
            cnt_d = '0;
        end
    end

    // Count register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_ip_sclk_gen.sv
// SPI serial-clock generator: produces a burst of 2N SCLK edges with an
// arbitrary half-period (div+1 system clocks), registered sample/shift
// strobes for all four CPOL/CPHA modes and a start/busy/done handshake.
// Optional guard intervals before and after the burst are enabled by
// defining SPI_IP_SCLK_GUARD_EN.
module spi_ip_sclk_gen
    import spi_ip_pkg::*;
#(
    parameter int PARAM_DIV_WIDTH   = DEF_DIV_WIDTH,
    parameter int PARAM_BITS_WIDTH  = DEF_BITS_WIDTH,
    parameter int PARAM_GUARD_WIDTH = DEF_GUARD_WIDTH
) (
    input  logic                         sckg_clk_i,
    input  logic                         sckg_rst_n_i,
    input  logic                         sckg_start_i,
    input  logic                         sckg_abort_i,
    input  logic                         sckg_cpol_i,
    input  logic                         sckg_cpha_i,
    input  logic [PARAM_DIV_WIDTH-1:0]   sckg_div_i,
    input  logic [PARAM_BITS_WIDTH-1:0]  sckg_bits_i,
`ifdef SPI_IP_SCLK_GUARD_EN
    input  logic [PARAM_GUARD_WIDTH-1:0] sckg_guard_i,
`endif
    output logic                         sckg_sclk_o,
    output logic                         sckg_sample_o,
    output logic                         sckg_shift_o,
    output logic                         sckg_busy_o,
    output logic                         sckg_done_o
);

    localparam int CNT_W  = (PARAM_DIV_WIDTH > PARAM_GUARD_WIDTH) ? PARAM_DIV_WIDTH : PARAM_GUARD_WIDTH;
    localparam int EDGE_W = PARAM_BITS_WIDTH + 1;

    sckg_state_e                 state_q, state_d;
    logic [PARAM_DIV_WIDTH-1:0]  div_q, div_d;
    logic [PARAM_BITS_WIDTH-1:0] bits_q, bits_d;
    logic [1:0]                  mode_q, mode_d;
    logic [EDGE_W-1:0]           edge_q, edge_d;
    logic                        sclk_q, sclk_d;
    logic                        sample_q, sample_d;
    logic                        shift_q, shift_d;
    logic                        done_q, done_d;

    logic [EDGE_W-1:0]           last_edge;
    logic [CNT_W-1:0]            limit;
    logic                        tick;
    logic                        cnt_clear;
    logic                        accept;
    logic                        abort_hit;
    logic                        guard_zero;
    logic                        guard_start_zero;

`ifdef SPI_IP_SCLK_GUARD_EN
    logic [PARAM_GUARD_WIDTH-1:0] guard_q, guard_d;
    assign guard_zero       = (guard_q == '0);
    assign guard_start_zero = (sckg_guard_i == '0);
`else
    assign guard_zero       = 1'b1;
    assign guard_start_zero = 1'b1;
`endif

    assign accept    = (state_q == ST_IDLE) && sckg_start_i;
    assign abort_hit = (state_q != ST_IDLE) && sckg_abort_i;
    assign last_edge = {bits_q, 1'b0} - EDGE_W'(1);
    assign cnt_clear = (state_q == ST_IDLE) || (state_d != state_q);

    // Counter limit: guard length in LEAD/LAG, half-period otherwise
    always_comb begin
        limit = CNT_W'(div_q);
`ifdef SPI_IP_SCLK_GUARD_EN
        if ((state_q == ST_LEAD) || (state_q == ST_LAG)) begin
            limit = CNT_W'(guard_q - PARAM_GUARD_WIDTH'(1));
        end
`endif
    end

    spi_ip_sclk_tick #(
        .PARAM_CNT_WIDTH (CNT_W)
    ) u_tick (
        .clk_i   (sckg_clk_i),
        .rst_n_i (sckg_rst_n_i),
        .clear_i (cnt_clear),
        .limit_i (limit),
        .tick_o  (tick)
    );

    // Burst configuration is captured only when a start is accepted
    always_comb begin
        div_d  = div_q;
        bits_d = bits_q;
        mode_d = mode_q;
`ifdef SPI_IP_SCLK_GUARD_EN
        guard_d = guard_q;
`endif
        if (accept) begin
            div_d                 = sckg_div_i;
            bits_d                = sckg_bits_i;
            mode_d[MODE_CPOL_BIT] = sckg_cpol_i;
            mode_d[MODE_CPHA_BIT] = sckg_cpha_i;
`ifdef SPI_IP_SCLK_GUARD_EN
            guard_d               = sckg_guard_i;
`endif
        end
    end

    // Next-state logic; abort from any busy state returns straight to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (sckg_start_i) begin
                    if (!guard_start_zero)      state_d = ST_LEAD;
                    else if (sckg_bits_i == '0) state_d = ST_TRAIL;
                    else                        state_d = ST_RUN;
                end
            end
            ST_LEAD: begin
                if (tick) state_d = (bits_q == '0) ? ST_TRAIL : ST_RUN;
            end
            ST_RUN: begin
                if (tick && (edge_q == last_edge)) state_d = ST_TRAIL;
            end
            ST_TRAIL: begin
                if (tick) state_d = guard_zero ? ST_DONE : ST_LAG;
            end
            ST_LAG: begin
                if (tick) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (abort_hit) begin
            state_d = ST_IDLE;
        end
    end

    // Output logic: SCLK level, edge index, strobes and completion pulse
    always_comb begin
        sclk_d   = sclk_q;
        edge_d   = edge_q;
        sample_d = 1'b0;
        shift_d  = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                sclk_d = sckg_cpol_i;
                edge_d = '0;
            end
            ST_RUN: begin
                if (tick) begin
                    sclk_d = ~sclk_q;
                    edge_d = edge_q + EDGE_W'(1);
                    if (mode_q[MODE_CPHA_BIT]) begin
                        shift_d  = ~edge_q[0];
                        sample_d = edge_q[0];
                    end else begin
                        sample_d = ~edge_q[0];
                        shift_d  = edge_q[0] && (edge_q != last_edge);
                    end
                end
            end
            ST_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                sclk_d = sclk_q;
            end
        endcase
        if (abort_hit) begin
            sclk_d   = mode_q[MODE_CPOL_BIT];
            edge_d   = '0;
            sample_d = 1'b0;
            shift_d  = 1'b0;
            done_d   = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge sckg_clk_i or negedge sckg_rst_n_i) begin
        if (!sckg_rst_n_i) begin
            state_q  <= ST_IDLE;
            div_q    <= '0;
            bits_q   <= '0;
            mode_q   <= '0;
            edge_q   <= '0;
            sclk_q   <= 1'b0;
            sample_q <= 1'b0;
            shift_q  <= 1'b0;
            done_q   <= 1'b0;
`ifdef SPI_IP_SCLK_GUARD_EN
            guard_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bits_q   <= bits_d;
            mode_q   <= mode_d;
            edge_q   <= edge_d;
            sclk_q   <= sclk_d;
            sample_q <= sample_d;
            shift_q  <= shift_d;
            done_q   <= done_d;
`ifdef SPI_IP_SCLK_GUARD_EN
            guard_q  <= guard_d;
`endif
        end
    end

    assign sckg_sclk_o   = sclk_q;
    assign sckg_sample_o = sample_q;
    assign sckg_shift_o  = shift_q;
    assign sckg_busy_o   = (state_q != ST_IDLE);
    assign sckg_done_o   = done_q;

endmodule

// File: tb/tb_spi_ip_sclk_gen.sv
// Testbench for spi_ip_sclk_gen. Directed bursts from the test plan followed
// by randomized bursts; every cycle of a burst is compared against a timing
// model derived from the burst parameters. With SPI_IP_SCLK_GUARD_EN the
// guard port is tied to 0, which keeps the macro-off timing.
module tb_spi_ip_sclk_gen;

    localparam int DivW   = 8;
    localparam int BitsW  = 6;
    localparam int GuardW = 4;

    logic              clk      = 1'b0;
    logic              rstN     = 1'b0;
    logic              start    = 1'b0;
    logic              abortReq = 1'b0;
    logic              cpol     = 1'b0;
    logic              cpha     = 1'b0;
    logic [DivW-1:0]   div      = '0;
    logic [BitsW-1:0]  bits     = '0;
`ifdef SPI_IP_SCLK_GUARD_EN
    logic [GuardW-1:0] guard    = '0;
`endif

    logic sclk, sample, shift, busy, done;

    int checks = 0;
    int errors = 0;

    // 10 time-unit system clock
    always #5 clk = ~clk;

    spi_ip_sclk_gen #(
        .PARAM_DIV_WIDTH   (DivW),
        .PARAM_BITS_WIDTH  (BitsW),
        .PARAM_GUARD_WIDTH (GuardW)
    ) dut (
        .sckg_clk_i    (clk),
        .sckg_rst_n_i  (rstN),
        .sckg_start_i  (start),
        .sckg_abort_i  (abortReq),
        .sckg_cpol_i   (cpol),
        .sckg_cpha_i   (cpha),
        .sckg_div_i    (div),
        .sckg_bits_i   (bits),
`ifdef SPI_IP_SCLK_GUARD_EN
        .sckg_guard_i  (guard),
`endif
        .sckg_sclk_o   (sclk),
        .sckg_sample_o (sample),
        .sckg_shift_o  (shift),
        .sckg_busy_o   (busy),
        .sckg_done_o   (done)
    );

    // Advance to just after the next rising edge, where outputs are stable
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Compare the packed {sclk,sample,shift,busy,done} vector with the model
    task automatic checkOutput(input string tag, input logic [4:0] expected);
        logic [4:0] observed;
        observed = {sclk, sample, shift, busy, done};
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed sclk/smp/sh/busy/done=%b expected %b", tag, observed, expected);
        end
    endtask

    // Expected outputs k cycles after the accepting edge T0. Edge j (0-based)
    // of 2N lands at T0+(j+1)*(div+1); the trail half-period and the one-cycle
    // DONE state put done at T0+(2N+1)*(div+1)+1.
    function automatic logic [4:0] modelAt(input int k, input bit pol, input bit pha,
                                           input int d, input int n);
        int   p, e, doneT, m, j;
        logic s, smp, sh, lead;
        p     = d + 1;
        e     = 2 * n;
        doneT = (e + 1) * p + 1;
        smp   = 1'b0;
        sh    = 1'b0;
        m     = k / p;
        if (m > e) m = e;
        s = pol ^ m[0];
        if ((k % p == 0) && (k / p >= 1) && (k / p <= e)) begin
            j    = k / p - 1;
            lead = (j % 2 == 0);
            if (!pha) begin
                smp = lead;
                sh  = !lead && (j != e - 1);
            end else begin
                sh  = lead;
                smp = !lead;
            end
        end
        return {s, smp, sh, (k < doneT), (k == doneT)};
    endfunction

    // Run one burst: optional idle cycle, start, then per-cycle checks up to
    // done (or up to the abort). perturb wiggles start/div/bits/cpha mid-burst.
    task automatic applyStimulus(input string name, input bit pol, input bit pha,
                                 input int d, input int n, input int abortAt,
                                 input bit perturb, input bit skipIdle);
        int doneT, last;
        doneT = (2 * n + 1) * (d + 1) + 1;
        last  = (abortAt > 0) ? abortAt : doneT;
        if (!skipIdle) begin
            cpol  = pol;
            start = 1'b0;
            stepCycle();
            checkOutput({name, "_idle"}, {pol, 4'b0000});
        end
        cpol  = pol;
        cpha  = pha;
        div   = d[DivW-1:0];
        bits  = n[BitsW-1:0];
        start = 1'b1;
        stepCycle();
        start = 1'b0;
        for (int k = 0; k <= last; k++) begin
            if (k > 0) stepCycle();
            abortReq = 1'b0;
            if ((abortAt > 0) && (k == abortAt))
                checkOutput($sformatf("%s_abort_k%0d", name, k), {pol, 4'b0000});
            else
                checkOutput($sformatf("%s_k%0d", name, k), modelAt(k, pol, pha, d, n));
            if ((abortAt > 0) && (k + 1 == abortAt)) abortReq = 1'b1;
            if (perturb && (k < last)) begin
                start = ($urandom_range(0, 2) == 0);
                div   = DivW'($urandom);
                bits  = BitsW'($urandom);
                cpha  = $urandom_range(0, 1);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    // Reset, directed test-plan bursts, then randomized bursts
    initial begin
        int d, n, doneT, ab;
        bit pol, pha, pert, skip;
        $display("[TB] start");

        cpol = 1'b1;
        #12;
        checkOutput("reset_async", 5'b00000);
        stepCycle();
        checkOutput("reset_hold", 5'b00000);
        rstN = 1'b1;
        stepCycle();
        checkOutput("reset_exit_sclk_tracks_cpol", 5'b10000);

        applyStimulus("mode0_div1_bits8", 1'b0, 1'b0, 1, 8, 0, 1'b0, 1'b0);
        applyStimulus("mode3_div0_bits4", 1'b1, 1'b1, 0, 4, 0, 1'b0, 1'b0);
        applyStimulus("mode0_div4_bits2", 1'b0, 1'b0, 4, 2, 0, 1'b0, 1'b0);
        applyStimulus("abort_mode0_div2", 1'b0, 1'b0, 2, 8, 10, 1'b0, 1'b0);
        applyStimulus("start_after_abort", 1'b0, 1'b1, 1, 3, 0, 1'b0, 1'b1);
        applyStimulus("perturbed_mode1", 1'b0, 1'b1, 2, 5, 0, 1'b1, 1'b0);
        applyStimulus("bits0_div3", 1'b1, 1'b0, 3, 0, 0, 1'b0, 1'b0);
        applyStimulus("start_on_done_cycle", 1'b1, 1'b0, 0, 1, 0, 1'b0, 1'b1);
        applyStimulus("mode2_bits_max", 1'b1, 1'b0, 0, 63, 0, 1'b0, 1'b0);

        for (int i = 0; i < 25; i++) begin
            pol   = $urandom_range(0, 1);
            pha   = $urandom_range(0, 1);
            d     = $urandom_range(0, 5);
            n     = $urandom_range(0, 9);
            doneT = (2 * n + 1) * (d + 1) + 1;
            ab    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, doneT) : 0;
            pert  = $urandom_range(0, 1);
            skip  = $urandom_range(0, 1);
            applyStimulus($sformatf("rand%0d", i), pol, pha, d, n, ab, pert, skip);
        end

        stepCycle();
        checkOutput("final_idle", {cpol, 4'b0000});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
